// File: rtl/crg_uart_pkg.sv
// Shared types and helpers for the CRG UART word link.
package crg_uart_pkg;

  // Start bit + 8 data bits + stop bit.
  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // Clock cycles per bit time (integer division; callers need a result >= 8).
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/crg_uart_rx_byte.sv
// 8N1 byte receiver: input synchroniser, bit timer and RX FSM.
// Emits one-cycle byte_ok / frame_err strobes; state is exported for debug
// and for the word-level timeout logic in the parent.
module crg_uart_rx_byte
  import crg_uart_pkg::*;
#(
  parameter int CPB = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] byte_data,
  output logic       byte_ok,
  output logic       frame_err,
  output rx_state_t  state
);

  localparam int CW = $clog2(CPB);

  logic          sync_1;
  logic          rxs;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  // Two-flop synchroniser; idles high like the line itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b1;
      rxs    <= 1'b1;
    end else begin
      sync_1 <= rx_in;
      rxs    <= sync_1;
    end
  end

  // Receive FSM: mid-bit sampling driven by a down-counting bit timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      byte_data <= '0;
      byte_ok   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_ok   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (!rxs) begin
            state <= RX_START;
            cnt   <= CW'(CPB / 2 - 1);
          end
        end
        RX_START: begin
          if (cnt == '0) begin
            if (!rxs) begin
              state   <= RX_DATA;
              cnt     <= CW'(CPB - 1);
              bit_idx <= '0;
            end else begin
              // Start bit did not hold to mid-bit: treat as a glitch.
              state <= RX_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == '0) begin
            shift <= {rxs, shift[7:1]};
            cnt   <= CW'(CPB - 1);
            if (bit_idx == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == '0) begin
            if (rxs) begin
              byte_data <= shift;
              byte_ok   <= 1'b1;
              state     <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= RX_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rxs) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/crg_uart_word_link.sv
// UART word link: assembles received 8N1 bytes into WORD_BYTES-byte words
// and serialises words back to the host, byte 0 first on both directions.
//
// Handshakes: a word transfers on a clock edge where valid and ready are both
// high. A source holds valid (and its data) until that edge; ready may be
// raised or lowered freely and never depends combinationally on valid.
module crg_uart_word_link
  import crg_uart_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BAUD         = 115_200,
  parameter int WORD_BYTES   = 4,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                    CLK100MHZ,
  input  logic                    ck_rst,
  input  logic                    uart_rx,
  output logic                    uart_tx,
  output logic [8*WORD_BYTES-1:0] rx_word,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  input  logic [8*WORD_BYTES-1:0] tx_word,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  input  logic                    err_clr,
  output logic                    rx_frame_err,
  output logic                    rx_overrun
);

  localparam int CPB        = clks_per_bit(CLK_HZ, BAUD);
  localparam int W          = 8 * WORD_BYTES;
  localparam int CW         = $clog2(CPB);
  localparam int BCW        = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TO_CYCLES  = TIMEOUT_BITS * CPB;
  localparam int TOW        = $clog2(TO_CYCLES);

  // ---------------- receive side ----------------
  logic [7:0]     rx_byte;
  logic           byte_ok;
  logic           byte_frame_err;
  rx_state_t      rx_state;

  logic [BCW-1:0] byte_cnt;
  logic [W-1:0]   word_buf;
  logic [W-1:0]   word_next;
  logic [TOW-1:0] to_cnt;
  logic           word_done;
  logic           timeout_hit;

  crg_uart_rx_byte #(
    .CPB(CPB)
  ) u_rx_byte (
    .clk       (CLK100MHZ),
    .rst       (ck_rst),
    .rx_in     (uart_rx),
    .byte_data (rx_byte),
    .byte_ok   (byte_ok),
    .frame_err (byte_frame_err),
    .state     (rx_state)
  );

  // Word buffer with the incoming byte dropped into its slot.
  always_comb begin
    word_next = word_buf;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (byte_cnt == BCW'(i)) word_next[i*8 +: 8] = rx_byte;
    end
  end

  assign word_done   = byte_ok && (byte_cnt == BCW'(WORD_BYTES - 1));
  assign timeout_hit = (to_cnt == TOW'(TO_CYCLES - 1));

  // Byte assembly, inter-byte timeout resync and the inter-byte idle counter.
  always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
    if (ck_rst) begin
      byte_cnt <= '0;
      word_buf <= '0;
      to_cnt   <= '0;
    end else begin
      if (byte_frame_err) begin
        byte_cnt <= '0;
        to_cnt   <= '0;
      end else if (byte_ok) begin
        word_buf <= word_next;
        to_cnt   <= '0;
        byte_cnt <= word_done ? '0 : byte_cnt + 1'b1;
      end else if (rx_state == RX_IDLE && byte_cnt != '0) begin
        if (timeout_hit) begin
          byte_cnt <= '0;
          to_cnt   <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  // Output register: accept a finished word if empty or draining this cycle.
  always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
    if (ck_rst) begin
      rx_word  <= '0;
      rx_valid <= 1'b0;
    end else begin
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (word_done && (!rx_valid || rx_ready)) begin
        rx_word  <= word_next;
        rx_valid <= 1'b1;
      end
    end
  end

  // Sticky error flags; a set in the same cycle as err_clr takes priority.
  always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
    if (ck_rst) begin
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      if (err_clr) begin
        rx_frame_err <= 1'b0;
        rx_overrun   <= 1'b0;
      end
      if (byte_frame_err) rx_frame_err <= 1'b1;
      if (word_done && rx_valid && !rx_ready) rx_overrun <= 1'b1;
    end
  end

  // ---------------- transmit side ----------------
  tx_state_t      tx_state;
  logic [W-1:0]   tx_shift;
  logic [CW-1:0]  tx_timer;
  logic [2:0]     tx_bit;
  logic [BCW-1:0] tx_byte_idx;

  // Transmit FSM: back-to-back frames for every byte of the latched word.
  always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
    if (ck_rst) begin
      tx_state    <= TX_IDLE;
      tx_shift    <= '0;
      tx_timer    <= '0;
      tx_bit      <= '0;
      tx_byte_idx <= '0;
      uart_tx     <= 1'b1;
      tx_ready    <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_valid && tx_ready) begin
            tx_shift    <= tx_word;
            tx_ready    <= 1'b0;
            uart_tx     <= 1'b0;
            tx_timer    <= CW'(CPB - 1);
            tx_byte_idx <= '0;
            tx_state    <= TX_START;
          end
        end
        TX_START: begin
          if (tx_timer == '0) begin
            uart_tx  <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_bit   <= '0;
            tx_timer <= CW'(CPB - 1);
            tx_state <= TX_DATA;
          end else begin
            tx_timer <= tx_timer - 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_timer == '0) begin
            tx_timer <= CW'(CPB - 1);
            if (tx_bit == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              uart_tx  <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_bit   <= tx_bit + 1'b1;
            end
          end else begin
            tx_timer <= tx_timer - 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_timer == '0) begin
            if (tx_byte_idx == BCW'(WORD_BYTES - 1)) begin
              tx_ready <= 1'b1;
              tx_state <= TX_IDLE;
            end else begin
              uart_tx     <= 1'b0;
              tx_timer    <= CW'(CPB - 1);
              tx_byte_idx <= tx_byte_idx + 1'b1;
              tx_state    <= TX_START;
            end
          end else begin
            tx_timer <= tx_timer - 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crg_uart_word_link.sv
// Directed bench for crg_uart_word_link with queue-based RX/TX scoreboards.
module tb_crg_uart_word_link;
  import crg_uart_pkg::*;

  localparam int CPB = 10;
  localparam int WB  = 4;
  localparam int W   = 8 * WB;

  logic         clk;
  logic         ck_rst;
  logic         uart_rx;
  logic         uart_tx;
  logic [W-1:0] rx_word;
  logic         rx_valid;
  logic         rx_ready;
  logic [W-1:0] tx_word;
  logic         tx_valid;
  logic         tx_ready;
  logic         err_clr;
  logic         rx_frame_err;
  logic         rx_overrun;

  logic [W-1:0] rx_exp_q[$];
  logic [W-1:0] tx_exp_q[$];
  int checks = 0;
  int errors = 0;
  logic rst_seen = 1'b0;

  crg_uart_word_link #(
    .CLK_HZ(1_000_000), .BAUD(100_000), .WORD_BYTES(WB), .TIMEOUT_BITS(20)
  ) dut (
    .CLK100MHZ(clk), .ck_rst(ck_rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .rx_word(rx_word), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_word(tx_word), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .err_clr(err_clr), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial forever begin
    @(posedge ck_rst);
    rst_seen = 1'b1;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int stop_len);
    uart_rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_cycles(CPB);
    end
    uart_rx = stop_bit;
    wait_cycles(stop_len);
    uart_rx = 1'b1;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = 0; i < WB; i++) send_byte(w[i*8 +: 8], 1'b1, CPB);
  endtask

  task automatic pulse_err_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // Handshake on the next rising edge; returns just after that edge.
  task automatic tx_handshake(input logic [W-1:0] w);
    @(negedge clk);
    tx_word  = w;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_word  = '0;
  endtask

  // ---------------- RX scoreboard monitor ----------------
  initial forever begin
    @(negedge clk);
    #1;
    if (!ck_rst && rx_valid && rx_ready) begin
      if (rx_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got word %h with nothing expected", rx_word);
      end else begin
        check("rx_word", rx_word, rx_exp_q.pop_front());
      end
    end
  end

  // ---------------- TX scoreboard monitor ----------------
  task automatic mon_wait(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] got;
    logic         frame_ok;
    forever begin
      @(negedge clk);
      #1;
      if (!ck_rst && uart_tx === 1'b0) begin
        rst_seen = 1'b0;
        frame_ok = 1'b1;
        got      = '0;
        mon_wait(4);
        for (int b = 0; b < WB; b++) begin
          if (b > 0) mon_wait(CPB);
          if (uart_tx !== 1'b0) frame_ok = 1'b0;
          for (int i = 0; i < 8; i++) begin
            mon_wait(CPB);
            got[b*8 + i] = uart_tx;
          end
          mon_wait(CPB);
          if (uart_tx !== 1'b1) frame_ok = 1'b0;
        end
        if (!rst_seen) begin
          if (tx_exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got word %h with nothing expected", got);
          end else begin
            check("tx_word", got, tx_exp_q.pop_front());
            check("tx_framing", {31'd0, frame_ok}, 32'd1);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int hs_to_ready;

  initial begin
    hs_to_ready = WB * FRAME_BITS * CPB;
    ck_rst   = 1'b1;
    uart_rx  = 1'b1;
    rx_ready = 1'b1;
    tx_word  = '0;
    tx_valid = 1'b0;
    err_clr  = 1'b0;
    wait_cycles(5);
    check("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_rx_word", rx_word, 32'd0);
    check("reset_flags", {30'd0, rx_frame_err, rx_overrun}, 32'd0);
    ck_rst = 1'b0;
    wait_cycles(20);

    // Clean RX word.
    rx_exp_q.push_back(32'h1234_5678);
    send_word(32'h1234_5678);
    wait_cycles(20);
    check("clean_flags", {30'd0, rx_frame_err, rx_overrun}, 32'd0);

    // TX word with exact start and ready timing.
    tx_exp_q.push_back(32'hA5C3_0FF0);
    tx_handshake(32'hA5C3_0FF0);
    check("tx_start_low", {31'd0, uart_tx}, 32'd0);
    check("tx_ready_low", {31'd0, tx_ready}, 32'd0);
    repeat (hs_to_ready - 1) @(posedge clk);
    #1;
    check("tx_ready_before_end", {31'd0, tx_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("tx_ready_at_end", {31'd0, tx_ready}, 32'd1);
    wait_cycles(20);

    // Framing error on the second byte, then a clean word.
    send_byte(8'hAA, 1'b1, CPB);
    send_byte(8'hBB, 1'b0, 30);
    wait_cycles(20);
    check("frame_err_set", {31'd0, rx_frame_err}, 32'd1);
    check("frame_no_valid", {31'd0, rx_valid}, 32'd0);
    rx_exp_q.push_back(32'h4433_2211);
    send_word(32'h4433_2211);
    wait_cycles(20);
    pulse_err_clr();
    wait_cycles(2);
    check("frame_err_cleared", {31'd0, rx_frame_err}, 32'd0);

    // Overrun: two words while the consumer stalls.
    @(negedge clk);
    rx_ready = 1'b0;
    rx_exp_q.push_back(32'hCAFE_0001);
    send_word(32'hCAFE_0001);
    send_word(32'hBEEF_0002);
    wait_cycles(20);
    check("overrun_flag", {31'd0, rx_overrun}, 32'd1);
    check("overrun_valid", {31'd0, rx_valid}, 32'd1);
    check("overrun_kept_word", rx_word, 32'hCAFE_0001);
    @(negedge clk);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("overrun_drain", {31'd0, rx_valid}, 32'd0);
    pulse_err_clr();
    wait_cycles(2);
    check("overrun_cleared", {31'd0, rx_overrun}, 32'd0);

    // Timeout resync after a partial word.
    send_byte(8'hAA, 1'b1, CPB);
    send_byte(8'hBB, 1'b1, CPB);
    wait_cycles(250);
    rx_exp_q.push_back(32'h0403_0201);
    send_word(32'h0403_0201);
    wait_cycles(20);

    // Short glitch gives no byte; the next word must align from byte 0.
    uart_rx = 1'b0;
    wait_cycles(3);
    uart_rx = 1'b1;
    wait_cycles(30);
    rx_exp_q.push_back(32'hDEAD_BEEF);
    send_word(32'hDEAD_BEEF);
    wait_cycles(20);

    // Reset in the middle of a TX word, then a normal transmission.
    tx_handshake(32'h1111_1111);
    wait_cycles(50);
    ck_rst = 1'b1;
    #1;
    check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    wait_cycles(3);
    ck_rst = 1'b0;
    wait_cycles(450);
    tx_exp_q.push_back(32'h5A3C_9617);
    tx_handshake(32'h5A3C_9617);
    check("post_rst_tx_start", {31'd0, uart_tx}, 32'd0);
    wait_cycles(hs_to_ready + 20);

    check("rx_queue_empty", rx_exp_q.size(), 32'd0);
    check("tx_queue_empty", tx_exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/crg_uart_word_link.md
# crg_uart_word_link

Parametrised UART word link between the host PC and the correlated-random-generator core, the generalised successor of the single-byte UART path on the Arty-A7 top. It deserialises 8N1 frames into WORD_BYTES-byte words, delivered with valid/ready, and serialises words back to the host. It adds inter-byte timeout resynchronisation, framing-error and overrun detection, and configurable clock, baud and word width.

## Interface
- CLK_HZ, 100_000_000: clock frequency in Hz
- BAUD, 115_200: line rate; CPB = CLK_HZ/BAUD (integer division, must be ≥ 8)
- WORD_BYTES, 4: bytes per word, ≥ 1; W = 8*WORD_BYTES
- TIMEOUT_BITS, 20: RX inter-byte timeout in bit times
- CLK100MHZ  in  1  system clock
- ck_rst  in  1  reset, asynchronous, active-high
- uart_rx  in  1  serial input from host, asynchronous to the clock
- uart_tx  out  1  serial output to host
- rx_word  out  W  received word, byte 0 in bits [7:0]
- rx_valid  out  1  rx_word holds an unconsumed word
- rx_ready  in  1  consumer accepts rx_word
- tx_word  in  W  word to send, byte 0 sent first
- tx_valid  in  1  tx_word is valid
- tx_ready  out  1  transmitter idle, can accept a word
- err_clr  in  1  clears sticky error flags
- rx_frame_err  out  1  sticky: stop bit sampled 0
- rx_overrun  out  1  sticky: a word was dropped because rx_valid was still set

## Operation
- Reset values: uart_tx=1, tx_ready=1, rx_valid=0, rx_word=0, both error flags 0, both FSMs IDLE, byte counters 0, synchroniser stages 1.
- uart_rx passes through a 2-FF synchroniser. All RX decisions use the synchronised signal rxs.
- RX FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rxs=0 → START, load the bit counter with CPB/2−1.
  - START: at counter expiry, rxs=0 → DATA with counter CPB−1. rxs=1 → IDLE (glitch, nothing recorded).
  - DATA: sample rxs at each expiry, 8 bits LSB-first, reloading CPB−1. After bit 7 → STOP.
  - STOP: sample at expiry.
    - rxs=1: byte written to slot byte_cnt, byte_cnt increments, → IDLE.
    - rxs=0: set rx_frame_err, discard the byte and the partial word (byte_cnt=0), → WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1, then → IDLE.
- Word completion: when byte WORD_BYTES−1 is accepted, byte_cnt wraps to 0 and the assembled word is offered to the output register.
  - Output register empty, or rx_valid&&rx_ready in the same cycle: load rx_word, rx_valid=1.
  - Otherwise: set rx_overrun, drop the new word, keep the old word.
- rx_valid&&rx_ready clears rx_valid next cycle unless a new word loads in that same cycle.
- Timeout: while in IDLE with byte_cnt≠0, a cycle counter runs. After TIMEOUT_BITS*CPB cycles without a start bit, byte_cnt=0. The counter restarts on every accepted byte.
- TX FSM states: IDLE, START, DATA, STOP.
  - tx_valid&&tx_ready latches tx_word into the shift register, tx_ready→0, → START.
  - Each frame: start bit 0, 8 data bits LSB-first, stop bit 1, each lasting CPB cycles.
  - Frames for bytes 0..WORD_BYTES−1 go back-to-back with no idle gap.
  - After the last stop bit → IDLE, tx_ready=1.
- err_clr clears both sticky flags. If a set and err_clr happen in the same cycle, the set wins.
- ck_rst asserted mid-operation aborts both FSMs immediately. A partial RX word is lost, and uart_tx returns to 1 asynchronously.

## Timing
- Synchroniser latency: 2 cycles from a uart_rx edge to rxs.
- RX: rx_valid rises 1 cycle after the mid-stop sample of the last byte. That sample occurs about 9.5*CPB cycles after the start edge reaches rxs.
- TX: uart_tx falls on the cycle after the handshake. For a handshake at cycle t, tx_ready is low for cycles t+1 .. t+WORD_BYTES*10*CPB and high again at t+1+WORD_BYTES*10*CPB.
- tx_word is sampled only at the handshake; changes afterwards have no effect.
- All outputs are registered. No combinational path from an input to an output.

## Structure
- Package crg_uart_pkg:
  - function clks_per_bit(CLK_HZ, BAUD)
  - enums rx_state_t and tx_state_t
  - constant FRAME_BITS=10
- Sub-module crg_uart_rx_byte: synchroniser, RX FSM and bit timer, emitting byte/byte_ok/frame_err strobes. Word assembly, timeout and the output register stay in the top.
- TX stays inline.

## Test plan
Bench parameters: CLK_HZ=1_000_000, BAUD=100_000 (CPB=10), WORD_BYTES=4, TIMEOUT_BITS=20.
- RX clean word: host sends bytes 0x78,0x56,0x34,0x12 with rx_ready=1 → rx_valid pulses once, rx_word=0x12345678, no error flags.
- TX word: tx_word=0xA5C30FF0 handshake at t → uart_tx low at t+1; bytes F0,0F,C3,A5 appear LSB-first; tx_ready high at t+401.
- Framing error: second byte sent with stop bit 0 and line held low 30 cycles → rx_frame_err=1, no rx_valid; the next 4 clean bytes yield exactly that word; err_clr clears the flag.
- Overrun: two full words sent with rx_ready=0 → rx_word stays the first word, rx_overrun=1; raising rx_ready drops rx_valid the next cycle.
- Timeout resync: 2 bytes, idle 250 cycles, then 4 bytes 0x01..0x04 → rx_word=0x04030201.
- Glitch and reset: a 3-cycle low pulse on uart_rx gives no byte. ck_rst asserted mid-TX forces uart_tx=1 and tx_ready=1 immediately; the next handshake transmits normally.
